// File: rtl/prt_pkg.sv
// Shared types and the lowest-free-slot encoder for the multi-slot
// packet reference table.
package prt_pkg;

    typedef enum logic [1:0] {
        SLOT_FREE    = 2'd0,
        SLOT_WRITING = 2'd1,
        SLOT_VALID   = 2'd2,
        SLOT_READING = 2'd3
    } slot_state_t;

    typedef enum logic {
        W_IDLE   = 1'b0,
        W_ACTIVE = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_ACTIVE = 1'b1
    } r_state_t;

    localparam int PRT_MAX_SLOTS = 32;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int prt_lowest_free(input logic [PRT_MAX_SLOTS-1:0] free_mask);
        int idx;
        idx = 0;
        for (int i = PRT_MAX_SLOTS - 1; i >= 0; i--) begin
            if (free_mask[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/prt_multislot_if.sv
// Handshake bundle between the PRT and its ingress/egress neighbours.
interface prt_multislot_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_SLOTS  = 4
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);

    logic                  EN_start_writing_prt_entry;
    logic                  RDY_start_writing_prt_entry;
    logic [SLOT_W-1:0]     start_writing_prt_entry;
    logic                  EN_write_prt_entry;
    logic [DATA_WIDTH-1:0] write_prt_entry_data;
    logic                  RDY_write_prt_entry;
    logic                  EN_finish_writing_prt_entry;
    logic                  RDY_finish_writing_prt_entry;
    logic                  write_overflow;
    logic                  EN_invalidate_prt_entry;
    logic [SLOT_W-1:0]     invalidate_prt_entry_slot;
    logic                  RDY_invalidate_prt_entry;
    logic                  EN_start_reading_prt_entry;
    logic [SLOT_W-1:0]     start_reading_prt_entry_slot;
    logic                  RDY_start_reading_prt_entry;
    logic                  EN_read_prt_entry;
    logic                  RDY_read_prt_entry;
    logic [DATA_WIDTH:0]   read_prt_entry;
    logic                  read_prt_entry_valid;
    logic                  is_prt_slot_free;
    logic [SLOT_W:0]       free_slot_count;

    modport slave (
        input  EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
               EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
               EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
        output RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
               RDY_finish_writing_prt_entry, write_overflow, RDY_invalidate_prt_entry,
               RDY_start_reading_prt_entry, RDY_read_prt_entry, read_prt_entry,
               read_prt_entry_valid, is_prt_slot_free, free_slot_count
    );

    modport master (
        output EN_start_writing_prt_entry, EN_write_prt_entry, write_prt_entry_data,
               EN_finish_writing_prt_entry, EN_invalidate_prt_entry, invalidate_prt_entry_slot,
               EN_start_reading_prt_entry, start_reading_prt_entry_slot, EN_read_prt_entry,
        input  RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
               RDY_finish_writing_prt_entry, write_overflow, RDY_invalidate_prt_entry,
               RDY_start_reading_prt_entry, RDY_read_prt_entry, read_prt_entry,
               read_prt_entry_valid, is_prt_slot_free, free_slot_count
    );
endinterface

// File: rtl/prt_frame_mem.sv
// Frame storage: one write port, one registered read port that holds its
// value when no read is requested. Array contents are never reset.
module prt_frame_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 6072,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_r[raddr];
        end
    end
endmodule

// File: rtl/prt_multislot.sv
// Multi-slot packet reference table: concurrent write and read channels over
// NUM_SLOTS frame slots, each with its own length and lifecycle state.
module prt_multislot
    import prt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 1518,
    parameter int NUM_SLOTS  = 4
) (
    input logic            CLK,
    input logic            RST,
    prt_multislot_if.slave bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int LEN_W  = $clog2(MEM_DEPTH + 1);
    localparam int ADDR_W = $clog2(NUM_SLOTS * MEM_DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(MEM_DEPTH);

    slot_state_t           slot_state_r [NUM_SLOTS];
    logic [LEN_W-1:0]      len_r [NUM_SLOTS];
    w_state_t              w_state_r, w_state_s;
    r_state_t              r_state_r, r_state_s;
    logic [SLOT_W-1:0]     w_slot_r, r_slot_r, pick_s;
    logic [LEN_W-1:0]      rd_ptr_r;
    logic                  overflow_r, rd_valid_r, rd_last_r, rd_zero_r;
    logic [NUM_SLOTS-1:0]  free_s;
    logic [SLOT_W:0]       free_cnt_s;
    logic                  start_w_s, wr_s, fin_s, inv_s, start_r_s, rd_s, rd_last_s, store_s;
    logic [ADDR_W-1:0]     waddr_s, raddr_s;
    logic [DATA_WIDTH-1:0] mem_q;

    // Free-slot mask from registered slot states
    always_comb begin
        free_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_s[i] = (slot_state_r[i] == SLOT_FREE);
        end
    end

    // Free-slot census and lowest-free pick
    always_comb begin
        free_cnt_s = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_cnt_s = free_cnt_s + {{SLOT_W{1'b0}}, free_s[i]};
        end
        pick_s = SLOT_W'(prt_lowest_free(PRT_MAX_SLOTS'(free_s)));
    end

    assign bus.RDY_start_writing_prt_entry  = (w_state_r == W_IDLE) && (free_cnt_s != '0);
    assign bus.start_writing_prt_entry      = pick_s;
    assign bus.RDY_write_prt_entry          = (w_state_r == W_ACTIVE);
    assign bus.RDY_finish_writing_prt_entry = (w_state_r == W_ACTIVE);
    assign bus.RDY_invalidate_prt_entry     = (slot_state_r[bus.invalidate_prt_entry_slot] == SLOT_VALID);
    // Invalidation of the same slot takes precedence over opening a read on it
    assign bus.RDY_start_reading_prt_entry  = (r_state_r == R_IDLE)
        && (slot_state_r[bus.start_reading_prt_entry_slot] == SLOT_VALID)
        && !(bus.EN_invalidate_prt_entry
             && (bus.invalidate_prt_entry_slot == bus.start_reading_prt_entry_slot));
    assign bus.RDY_read_prt_entry           = (r_state_r == R_ACTIVE);

    assign start_w_s = bus.EN_start_writing_prt_entry  && bus.RDY_start_writing_prt_entry;
    assign wr_s      = bus.EN_write_prt_entry          && bus.RDY_write_prt_entry;
    assign fin_s     = bus.EN_finish_writing_prt_entry && bus.RDY_finish_writing_prt_entry;
    assign inv_s     = bus.EN_invalidate_prt_entry     && bus.RDY_invalidate_prt_entry;
    assign start_r_s = bus.EN_start_reading_prt_entry  && bus.RDY_start_reading_prt_entry;
    assign rd_s      = bus.EN_read_prt_entry           && bus.RDY_read_prt_entry;

    assign store_s   = wr_s && (len_r[w_slot_r] < DEPTH_L);
    assign rd_last_s = (len_r[r_slot_r] == '0) || (rd_ptr_r == (len_r[r_slot_r] - LEN_W'(1)));
    assign waddr_s   = ADDR_W'(w_slot_r) * ADDR_W'(MEM_DEPTH) + ADDR_W'(len_r[w_slot_r]);
    assign raddr_s   = ADDR_W'(r_slot_r) * ADDR_W'(MEM_DEPTH) + ADDR_W'(rd_ptr_r);

    // Next-state logic for the write and read channel FSMs
    always_comb begin
        w_state_s = w_state_r;
        r_state_s = r_state_r;
        case (w_state_r)
            W_IDLE:   if (start_w_s) w_state_s = W_ACTIVE; else w_state_s = W_IDLE;
            W_ACTIVE: if (fin_s)     w_state_s = W_IDLE;   else w_state_s = W_ACTIVE;
            default:  w_state_s = W_IDLE;
        endcase
        case (r_state_r)
            R_IDLE:   if (start_r_s)         r_state_s = R_ACTIVE; else r_state_s = R_IDLE;
            R_ACTIVE: if (rd_s && rd_last_s) r_state_s = R_IDLE;   else r_state_s = R_ACTIVE;
            default:  r_state_s = R_IDLE;
        endcase
    end

    // Channel FSM state registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state_r <= W_IDLE;
            r_state_r <= R_IDLE;
        end else begin
            w_state_r <= w_state_s;
            r_state_r <= r_state_s;
        end
    end

    // Slot lifecycle, lengths, channel slot/pointer and overflow bookkeeping
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_state_r[i] <= SLOT_FREE;
                len_r[i]        <= '0;
            end
            w_slot_r   <= '0;
            r_slot_r   <= '0;
            rd_ptr_r   <= '0;
            overflow_r <= 1'b0;
        end else begin
            if (start_w_s) begin
                slot_state_r[pick_s] <= SLOT_WRITING;
                len_r[pick_s]        <= '0;
                w_slot_r             <= pick_s;
                overflow_r           <= 1'b0;
            end
            if (store_s) begin
                len_r[w_slot_r] <= len_r[w_slot_r] + LEN_W'(1);
            end
            if (wr_s && !store_s) begin
                overflow_r <= 1'b1;
            end
            if (fin_s) begin
                slot_state_r[w_slot_r] <= SLOT_VALID;
            end
            if (inv_s) begin
                slot_state_r[bus.invalidate_prt_entry_slot] <= SLOT_FREE;
            end
            if (start_r_s) begin
                slot_state_r[bus.start_reading_prt_entry_slot] <= SLOT_READING;
                r_slot_r <= bus.start_reading_prt_entry_slot;
                rd_ptr_r <= '0;
            end
            if (rd_s) begin
                rd_ptr_r <= rd_ptr_r + LEN_W'(1);
                if (rd_last_s) begin
                    slot_state_r[r_slot_r] <= SLOT_VALID;
                end
            end
        end
    end

    // Read-side output qualifiers; a zero-length frame masks the data word
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
            rd_zero_r  <= 1'b0;
        end else begin
            rd_valid_r <= rd_s;
            if (rd_s) begin
                rd_last_r <= rd_last_s;
                rd_zero_r <= (len_r[r_slot_r] == '0);
            end
        end
    end

    prt_frame_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (NUM_SLOTS * MEM_DEPTH)
    ) u_mem (
        .clk   (CLK),
        .rst   (RST),
        .we    (store_s),
        .waddr (waddr_s),
        .wdata (bus.write_prt_entry_data),
        .re    (rd_s),
        .raddr (raddr_s),
        .rdata (mem_q)
    );

    assign bus.read_prt_entry       = {rd_last_r, (rd_zero_r ? {DATA_WIDTH{1'b0}} : mem_q)};
    assign bus.read_prt_entry_valid = rd_valid_r;
    assign bus.write_overflow       = overflow_r;
    assign bus.is_prt_slot_free     = (free_cnt_s != '0);
    assign bus.free_slot_count      = free_cnt_s;
endmodule

// File: tb/tb_prt_multislot.sv
// Scoreboard bench for prt_multislot: per-cycle requests update a frame-level
// model; expected read words are queued and checked by a separate monitor.
module tb_prt_multislot;
    localparam int DW = 8;
    localparam int DEPTH = 12;
    localparam int NS = 4;
    localparam int ST_FREE = 0, ST_WRITING = 1, ST_VALID = 2, ST_READING = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prt_multislot_if #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) bus ();
    prt_multislot #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .NUM_SLOTS(NS)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] frames [NS][$];
    int         st [NS];
    bit         w_act, r_act, ov;
    int         w_slot, r_slot, r_ptr;
    logic [8:0] exp_q [$];
    logic [7:0] wq [$];
    logic [8:0] held = 9'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            st[s] = ST_FREE;
            frames[s].delete();
        end
        w_act = 1'b0; r_act = 1'b0; ov = 1'b0;
        w_slot = 0; r_slot = 0; r_ptr = 0;
        exp_q.delete();
    endtask

    // Monitor: pop expected words whenever the DUT presents one; otherwise the output must hold
    always @(negedge clk) begin
        if (rst) begin
            held = 9'h000;
        end else if (bus.read_prt_entry_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read_word", 32'(bus.read_prt_entry), 32'h1ff);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                chk("read_word", 32'(bus.read_prt_entry), 32'(e));
                held = e;
            end
        end else begin
            chk("read_hold", 32'(bus.read_prt_entry), 32'(held));
        end
    end

    // One clock cycle of requests: check ready/status against the model, update the model, tick
    task automatic cycle_op(input bit sw, input bit w, input logic [7:0] wd, input bit fin,
                            input bit inv, input int inv_slot, input bit sr, input int sr_slot,
                            input bit rd);
        bit e_sw, e_inv, e_sr, last;
        int nfree, pick, len;
        logic [8:0] e;
        bus.EN_start_writing_prt_entry   = sw;
        bus.EN_write_prt_entry           = w;
        bus.write_prt_entry_data         = wd;
        bus.EN_finish_writing_prt_entry  = fin;
        bus.EN_invalidate_prt_entry      = inv;
        bus.invalidate_prt_entry_slot    = 2'(inv_slot);
        bus.EN_start_reading_prt_entry   = sr;
        bus.start_reading_prt_entry_slot = 2'(sr_slot);
        bus.EN_read_prt_entry            = rd;
        #1;
        nfree = 0; pick = -1;
        for (int s = 0; s < NS; s++) begin
            if (st[s] == ST_FREE) begin
                nfree++;
                if (pick < 0) pick = s;
            end
        end
        e_sw  = !w_act && (nfree > 0);
        e_inv = (st[inv_slot] == ST_VALID);
        e_sr  = !r_act && (st[sr_slot] == ST_VALID) && !(inv && (inv_slot == sr_slot));
        chk("free_count", 32'(bus.free_slot_count), 32'(nfree));
        chk("slot_free", 32'(bus.is_prt_slot_free), 32'(nfree > 0));
        chk("rdy_start_write", 32'(bus.RDY_start_writing_prt_entry), 32'(e_sw));
        if (e_sw) chk("write_pick", 32'(bus.start_writing_prt_entry), 32'(pick));
        chk("rdy_write", 32'(bus.RDY_write_prt_entry), 32'(w_act));
        chk("rdy_finish", 32'(bus.RDY_finish_writing_prt_entry), 32'(w_act));
        chk("rdy_invalidate", 32'(bus.RDY_invalidate_prt_entry), 32'(e_inv));
        chk("rdy_start_read", 32'(bus.RDY_start_reading_prt_entry), 32'(e_sr));
        chk("rdy_read", 32'(bus.RDY_read_prt_entry), 32'(r_act));
        chk("overflow", 32'(bus.write_overflow), 32'(ov));
        if (w && w_act) begin
            if (frames[w_slot].size() < DEPTH) frames[w_slot].push_back(wd);
            else ov = 1'b1;
        end
        if (fin && w_act) begin
            st[w_slot] = ST_VALID;
            w_act = 1'b0;
        end
        if (inv && e_inv) st[inv_slot] = ST_FREE;
        if (rd && r_act) begin
            len = frames[r_slot].size();
            if (len == 0) begin
                last = 1'b1;
                e = 9'h100;
            end else begin
                last = (r_ptr == len - 1);
                e = {last, frames[r_slot][r_ptr]};
            end
            exp_q.push_back(e);
            r_ptr++;
            if (last) begin
                st[r_slot] = ST_VALID;
                r_act = 1'b0;
            end
        end
        if (sr && e_sr) begin
            st[sr_slot] = ST_READING;
            r_slot = sr_slot; r_ptr = 0; r_act = 1'b1;
        end
        if (sw && e_sw) begin
            st[pick] = ST_WRITING;
            frames[pick].delete();
            w_slot = pick; w_act = 1'b1; ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle_op(0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic write_frame(input int n);
        logic [7:0] wd;
        cycle_op(1, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) begin
            wd = (wq.size() > 0) ? wq.pop_front() : 8'($urandom);
            cycle_op(0, 1, wd, 0, 0, 0, 0, 0, 0);
        end
        cycle_op(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic read_frame(input int slot);
        cycle_op(0, 0, 8'h00, 0, 0, 0, 1, slot, 0);
        for (int k = 0; k < 64 && r_act; k++) begin
            cycle_op(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        end
    endtask

    initial begin
        model_reset();
        bus.EN_start_writing_prt_entry = 1'b0;  bus.EN_write_prt_entry = 1'b0;
        bus.write_prt_entry_data = 8'h00;       bus.EN_finish_writing_prt_entry = 1'b0;
        bus.EN_invalidate_prt_entry = 1'b0;     bus.invalidate_prt_entry_slot = 2'd0;
        bus.EN_start_reading_prt_entry = 1'b0;  bus.start_reading_prt_entry_slot = 2'd0;
        bus.EN_read_prt_entry = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_read_data", 32'(bus.read_prt_entry), 32'h0);
        chk("reset_read_valid", 32'(bus.read_prt_entry_valid), 32'h0);
        chk("reset_overflow", 32'(bus.write_overflow), 32'h0);
        chk("reset_slot_free", 32'(bus.is_prt_slot_free), 32'h1);
        chk("reset_free_count", 32'(bus.free_slot_count), 32'd4);
        @(posedge clk);
        #1 rst = 1'b0;

        // Basic three-word frame into slot 0 and readback
        wq = '{8'hA1, 8'hB2, 8'hC3};
        write_frame(3);
        read_frame(0);
        idle();
        chk("basic_free_count", 32'(bus.free_slot_count), 32'd3);

        // Fill every slot, then free slot 2
        for (int i = 0; i < 3; i++) write_frame($urandom_range(1, DEPTH));
        chk("full_slot_free", 32'(bus.is_prt_slot_free), 32'h0);
        chk("full_rdy_start_write", 32'(bus.RDY_start_writing_prt_entry), 32'h0);
        cycle_op(0, 0, 8'h00, 0, 1, 2, 0, 0, 0);
        chk("inval_free_count", 32'(bus.free_slot_count), 32'd1);
        chk("inval_pick", 32'(bus.start_writing_prt_entry), 32'd2);

        // Overflow: two words beyond capacity
        write_frame(DEPTH + 2);
        chk("overflow_set", 32'(bus.write_overflow), 32'h1);
        read_frame(2);
        cycle_op(0, 0, 8'h00, 0, 1, 2, 0, 0, 0);

        // Zero-length frame, then replay of slot 0
        write_frame(0);
        chk("zero_len_overflow", 32'(bus.write_overflow), 32'h0);
        read_frame(2);
        read_frame(0);

        // Concurrency: free slot 1, then start-write, start-read and invalidate together
        cycle_op(0, 0, 8'h00, 0, 1, 1, 0, 0, 0);
        cycle_op(1, 0, 8'h00, 0, 1, 2, 1, 0, 0);
        for (int i = 0; i < 5; i++) cycle_op(0, 1, 8'($urandom), 0, 0, 0, 0, 0, 1);
        cycle_op(0, 0, 8'h00, 1, 0, 0, 0, 0, 1);
        chk("conc_free_count", 32'(bus.free_slot_count), 32'd1);
        read_frame(1);
        cycle_op(0, 0, 8'h00, 0, 1, 3, 1, 3, 0);
        idle();
        chk("inval_beats_read", 32'(bus.RDY_read_prt_entry), 32'h0);
        chk("inval_beats_read_count", 32'(bus.free_slot_count), 32'd2);

        // Reset in the middle of a ten-word read
        write_frame(10);
        cycle_op(0, 0, 8'h00, 0, 0, 0, 1, w_slot, 0);
        for (int i = 0; i < 3; i++) cycle_op(0, 0, 8'h00, 0, 0, 0, 0, 0, 1);
        #1 rst = 1'b1;
        #1;
        chk("midreset_valid", 32'(bus.read_prt_entry_valid), 32'h0);
        chk("midreset_data", 32'(bus.read_prt_entry), 32'h0);
        chk("midreset_free_count", 32'(bus.free_slot_count), 32'd4);
        chk("midreset_slot_free", 32'(bus.is_prt_slot_free), 32'h1);
        model_reset();
        bus.EN_read_prt_entry = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Randomised mixed traffic
        for (int c = 0; c < 400; c++) begin
            cycle_op($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 8'($urandom),
                     $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                     int'($urandom_range(0, NS - 1)), $urandom_range(0, 2) == 0,
                     int'($urandom_range(0, NS - 1)), $urandom_range(0, 2) != 0);
        end
        repeat (3) idle();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
